// File: rtl/bsg_global_buffer_pkg.sv
// Shared types and width helpers for the global-buffer read/write arbiter.

// Request bundle carried from a requester to the shared channel.
`define BSG_GB_REQ_STRUCT(addr_w, data_w) \
    struct packed {                       \
        logic [addr_w-1:0] addr;          \
        logic [data_w-1:0] data;          \
        logic              w;             \
    }

package bsg_global_buffer_pkg;

    // clog2 that never collapses to a zero-width vector
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Width of a requester ID, clog2(num_req)
    function automatic int id_width(input int num_req);
        return safe_clog2(num_req);
    endfunction

    // Width of an outstanding-request count, clog2(max_outstanding + 1)
    function automatic int count_width(input int max_outstanding);
        return safe_clog2(max_outstanding + 1);
    endfunction

    localparam int default_num_req_lp         = 4;
    localparam int default_max_outstanding_lp = 4;
    localparam int default_id_width_lp        = id_width(default_num_req_lp);
    localparam int default_count_width_lp     = count_width(default_max_outstanding_lp);

endpackage

// File: rtl/bsg_global_buffer_id_fifo.sv
// Circular buffer of requester IDs recording the issue order of in-flight
// requests. Occupancy is tracked by an explicit count, not pointer compare.

module bsg_global_buffer_id_fifo
    import bsg_global_buffer_pkg::*;
#(
    parameter int els_p         = 4,
    parameter int width_p       = 2,
    parameter int count_width_p = 3
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push_i,
    input  logic [width_p-1:0]       data_i,
    input  logic                     pop_i,
    output logic [width_p-1:0]       head_o,
    output logic [count_width_p-1:0] count_o
);

    localparam int ptr_w_lp = safe_clog2(els_p);

    logic [width_p-1:0]       mem_q [els_p];
    logic [ptr_w_lp-1:0]      wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]      rd_ptr_q, rd_ptr_d;
    logic [count_width_p-1:0] count_q, count_d;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Advance pointers and occupancy on push/pop
    always_comb begin
        wr_ptr_d = push_i ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_i  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + count_width_p'(push_i) - count_width_p'(pop_i);
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bsg_global_buffer_rw_arbiter.sv
// Round-robin, credit-limited sharing of one global-buffer rw channel among
// several requesters, with in-order response routing and per-requester fences.

module bsg_global_buffer_rw_arbiter
    import bsg_global_buffer_pkg::*;
#(
    parameter int num_req_p         = 4,
    parameter int rw_addr_width_p   = 16,
    parameter int data_width_p      = 32,
    parameter int max_outstanding_p = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic [num_req_p-1:0][rw_addr_width_p-1:0] req_addr_i,
    input  logic [num_req_p-1:0][data_width_p-1:0]    req_data_i,
    input  logic [num_req_p-1:0]                      req_w_i,
    input  logic [num_req_p-1:0]                      req_v_i,
    output logic [num_req_p-1:0]                      req_ready_o,
    output logic [num_req_p-1:0][data_width_p-1:0]    resp_data_o,
    output logic [num_req_p-1:0]                      resp_v_o,
    input  logic [num_req_p-1:0]                      resp_yumi_i,
    output logic [num_req_p-1:0]                      fence_o,
    output logic [rw_addr_width_p-1:0]                gb_addr_o,
    output logic [data_width_p-1:0]                   gb_data_o,
    output logic                                      gb_w_o,
    output logic                                      gb_v_o,
    input  logic                                      gb_ready_i,
    input  logic [data_width_p-1:0]                   gb_data_i,
    input  logic                                      gb_v_i,
    output logic                                      gb_yumi_o
);

    localparam int id_w_lp  = id_width(num_req_p);
    localparam int cnt_w_lp = count_width(max_outstanding_p);

    typedef `BSG_GB_REQ_STRUCT(rw_addr_width_p, data_width_p) req_s;

    logic [id_w_lp-1:0]  rr_q, rr_d;
    logic [cnt_w_lp-1:0] cnt_q [num_req_p];
    logic [cnt_w_lp-1:0] cnt_d [num_req_p];
    logic [cnt_w_lp-1:0] total_count;
    logic [id_w_lp-1:0]  grant_id;
    logic [id_w_lp-1:0]  head_id;
    logic                grant_found;
    logic                credit_ok;
    logic                accept;
    logic                resp_fire;
    logic                cnt_ovf;
    req_s                reqs [num_req_p];
    req_s                grant_req;

    // Pack each requester's inputs into a request bundle
    always_comb begin
        for (int i = 0; i < num_req_p; i++) begin
            reqs[i].addr = req_addr_i[i];
            reqs[i].data = req_data_i[i];
            reqs[i].w    = req_w_i[i];
        end
    end

    // Round-robin search: first valid requester at or after the pointer
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!grant_found && req_v_i[idx]) begin
                grant_found = 1'b1;
                grant_id    = id_w_lp'(idx);
            end
        end
    end

    // A pop in the same cycle does not free a credit
    assign credit_ok = (total_count < cnt_w_lp'(max_outstanding_p));
    assign gb_v_o    = grant_found & credit_ok & ~reset_i;
    assign accept    = gb_v_o & gb_ready_i;
    assign grant_req = reqs[grant_id];
    assign gb_addr_o = grant_req.addr;
    assign gb_data_o = grant_req.data;
    assign gb_w_o    = grant_req.w;

    // One-hot accept strobe to the granted requester
    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[grant_id] = 1'b1;
    end

    // Responses return in issue order to the requester at the FIFO head
    assign resp_fire = gb_v_i & (total_count != '0);
    assign gb_yumi_o = resp_fire & resp_yumi_i[head_id];

    always_comb begin
        resp_v_o = '0;
        if (resp_fire) resp_v_o[head_id] = 1'b1;
        for (int i = 0; i < num_req_p; i++) resp_data_o[i] = gb_data_i;
    end

    // Next pointer and per-requester outstanding counts
    always_comb begin
        rr_d    = rr_q;
        cnt_ovf = 1'b0;
        if (accept) begin
            rr_d = (grant_id == id_w_lp'(num_req_p - 1)) ? '0 : grant_id + id_w_lp'(1);
        end
        for (int i = 0; i < num_req_p; i++) begin
            logic inc, dec;
            inc = accept    && (grant_id == id_w_lp'(i));
            dec = gb_yumi_o && (head_id  == id_w_lp'(i));
            cnt_d[i] = cnt_q[i] + cnt_w_lp'(inc) - cnt_w_lp'(dec);
            if (inc && !dec && (cnt_q[i] == cnt_w_lp'(max_outstanding_p))) cnt_ovf = 1'b1;
        end
    end

    // Arbitration and tracking state, discarded asynchronously on reset
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rr_q <= '0;
            for (int i = 0; i < num_req_p; i++) cnt_q[i] <= '0;
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < num_req_p; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Fence derives only from registered counts
    always_comb begin
        for (int i = 0; i < num_req_p; i++) fence_o[i] = (cnt_q[i] == '0);
    end

    bsg_global_buffer_id_fifo #(
        .els_p         (max_outstanding_p),
        .width_p       (id_w_lp),
        .count_width_p (cnt_w_lp)
    ) id_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (accept),
        .data_i  (grant_id),
        .pop_i   (gb_yumi_o),
        .head_o  (head_id),
        .count_o (total_count)
    );

    // Responses must never arrive with nothing outstanding
    a_resp_without_req: assert property (@(posedge clk_i) disable iff (reset_i)
        !(gb_v_i && (total_count == '0)));

    // Consumers may only take a response presented to them
    a_yumi_without_v: assert property (@(posedge clk_i) disable iff (reset_i)
        ((resp_yumi_i & ~resp_v_o) == '0));

    // Per-requester count must not wrap
    a_count_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
        !cnt_ovf);

endmodule

// File: tb/tb_bsg_global_buffer_rw_arbiter.sv
// Directed bench for the global-buffer rw arbiter.

module tb_bsg_global_buffer_rw_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                   clk_i = 1'b0;
    logic                   reset_i;
    logic [NR-1:0][AW-1:0]  req_addr_i;
    logic [NR-1:0][DW-1:0]  req_data_i;
    logic [NR-1:0]          req_w_i;
    logic [NR-1:0]          req_v_i;
    logic [NR-1:0]          req_ready_o;
    logic [NR-1:0][DW-1:0]  resp_data_o;
    logic [NR-1:0]          resp_v_o;
    logic [NR-1:0]          resp_yumi_i;
    logic [NR-1:0]          fence_o;
    logic [AW-1:0]          gb_addr_o;
    logic [DW-1:0]          gb_data_o;
    logic                   gb_w_o;
    logic                   gb_v_o;
    logic                   gb_ready_i;
    logic [DW-1:0]          gb_data_i;
    logic                   gb_v_i;
    logic                   gb_yumi_o;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    bsg_global_buffer_rw_arbiter #(
        .num_req_p         (NR),
        .rw_addr_width_p   (AW),
        .data_width_p      (DW),
        .max_outstanding_p (MO)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .req_addr_i  (req_addr_i),
        .req_data_i  (req_data_i),
        .req_w_i     (req_w_i),
        .req_v_i     (req_v_i),
        .req_ready_o (req_ready_o),
        .resp_data_o (resp_data_o),
        .resp_v_o    (resp_v_o),
        .resp_yumi_i (resp_yumi_i),
        .fence_o     (fence_o),
        .gb_addr_o   (gb_addr_o),
        .gb_data_o   (gb_data_o),
        .gb_w_o      (gb_w_o),
        .gb_v_o      (gb_v_o),
        .gb_ready_i  (gb_ready_i),
        .gb_data_i   (gb_data_i),
        .gb_v_i      (gb_v_i),
        .gb_yumi_o   (gb_yumi_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i     = 1'b1;
        req_v_i     = '0;
        req_w_i     = '0;
        resp_yumi_i = '0;
        gb_ready_i  = 1'b1;
        gb_v_i      = 1'b0;
        gb_data_i   = '0;
        for (int i = 0; i < NR; i++) begin
            req_addr_i[i] = AW'(16'h1000 + i);
            req_data_i[i] = DW'(32'hD000_0000 + i);
        end

        // reset state, with requests pending
        req_v_i = 4'b1111;
        step();
        step();
        chk("rst_fence", 64'(fence_o), 64'hF);
        chk("rst_gb_v", 64'(gb_v_o), 64'h0);
        chk("rst_ready", 64'(req_ready_o), 64'h0);
        chk("rst_resp_v", 64'(resp_v_o), 64'h0);
        chk("rst_yumi", 64'(gb_yumi_o), 64'h0);
        reset_i = 1'b0;

        // round-robin fairness, credit cap at 4
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready_o), 64'(1 << k));
            chk("rr_addr", 64'(gb_addr_o), 64'(16'h1000 + k));
            step();
        end
        chk("rr_cap_gb_v", 64'(gb_v_o), 64'h0);
        chk("rr_cap_ready", 64'(req_ready_o), 64'h0);
        chk("rr_fence", 64'(fence_o), 64'h0);

        // drain in order 0..3
        req_v_i = '0;
        gb_v_i  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            gb_data_i   = DW'(32'hAA00 + k);
            resp_yumi_i = NR'(1 << k);
            #1;
            chk("drain_resp_v", 64'(resp_v_o), 64'(1 << k));
            chk("drain_yumi", 64'(gb_yumi_o), 64'h1);
            step();
        end
        gb_v_i      = 1'b0;
        resp_yumi_i = '0;
        chk("drain_fence", 64'(fence_o), 64'hF);

        // in-order routing: r2 read, r0 write, r2 read (pointer at 0)
        req_w_i = 4'b0001;
        req_v_i = 4'b0100; #1; chk("io_ready_a", 64'(req_ready_o), 64'h4); step();
        req_v_i = 4'b0001; #1; chk("io_ready_b", 64'(req_ready_o), 64'h1);
        chk("io_w_b", 64'(gb_w_o), 64'h1); step();
        req_v_i = 4'b0100; #1; chk("io_ready_c", 64'(req_ready_o), 64'h4); step();
        req_v_i = '0;
        chk("io_fence", 64'(fence_o), 64'hA);

        // backpressure on the head response
        gb_v_i    = 1'b1;
        gb_data_i = 32'hA0A0_A0A0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_resp_v", 64'(resp_v_o), 64'h4);
            chk("bp_yumi", 64'(gb_yumi_o), 64'h0);
            chk("bp_data", 64'(resp_data_o[2]), 64'hA0A0_A0A0);
            step();
        end
        chk("bp_fence", 64'(fence_o), 64'hA);

        resp_yumi_i = 4'b0100; #1;
        chk("io_yumi_a", 64'(gb_yumi_o), 64'h1); step();
        chk("io_fence_a", 64'(fence_o), 64'hA);
        gb_data_i = 32'hB0B0_B0B0; resp_yumi_i = 4'b0001; #1;
        chk("io_resp_b", 64'(resp_v_o), 64'h1);
        chk("io_data_b", 64'(resp_data_o[0]), 64'hB0B0_B0B0); step();
        chk("io_fence_b", 64'(fence_o), 64'hB);
        gb_data_i = 32'hC0C0_C0C0; resp_yumi_i = 4'b0100; #1;
        chk("io_resp_c", 64'(resp_v_o), 64'h4); step();
        chk("io_fence_c", 64'(fence_o), 64'hF);
        gb_v_i      = 1'b0;
        resp_yumi_i = '0;
        req_w_i     = '0;

        // fill to 3 outstanding from pointer 3: grants 3, 0, 1
        req_v_i = 4'b1111;
        #1; chk("pp_fill0", 64'(req_ready_o), 64'h8); step();
        #1; chk("pp_fill1", 64'(req_ready_o), 64'h1); step();
        #1; chk("pp_fill2", 64'(req_ready_o), 64'h2); step();

        // simultaneous push (grant 2) and pop (head 3) at count 3
        gb_v_i      = 1'b1;
        resp_yumi_i = 4'b1000;
        #1;
        chk("pp_ready", 64'(req_ready_o), 64'h4);
        chk("pp_resp_v", 64'(resp_v_o), 64'h8);
        chk("pp_yumi", 64'(gb_yumi_o), 64'h1);
        step();
        chk("pp_fence", 64'(fence_o), 64'h8);
        chk("pp_credit", 64'(gb_v_o), 64'h1);

        // six more push+pop pairs across the FIFO wrap: grant 3+k, head k
        for (int k = 0; k < 6; k++) begin
            gb_data_i   = DW'(32'h5500 + k);
            resp_yumi_i = NR'(1 << (k % 4));
            #1;
            chk("wrap_ready", 64'(req_ready_o), 64'(1 << ((3 + k) % 4)));
            chk("wrap_resp_v", 64'(resp_v_o), 64'(1 << (k % 4)));
            chk("wrap_data", 64'(resp_data_o[k % 4]), 64'(32'h5500 + k));
            step();
        end

        // drain remaining heads 2, 3, 0
        req_v_i = '0;
        resp_yumi_i = 4'b0100; #1; chk("wd_resp2", 64'(resp_v_o), 64'h4); step();
        resp_yumi_i = 4'b1000; #1; chk("wd_resp3", 64'(resp_v_o), 64'h8); step();
        resp_yumi_i = 4'b0001; #1; chk("wd_resp0", 64'(resp_v_o), 64'h1); step();
        gb_v_i      = 1'b0;
        resp_yumi_i = '0;
        chk("wd_fence", 64'(fence_o), 64'hF);

        // three outstanding (pointer 1): grants 1, 1, 2, leaving pointer at 3
        req_v_i = 4'b0010; #1; chk("ar_g0", 64'(req_ready_o), 64'h2); step();
        req_v_i = 4'b0010; #1; chk("ar_g1", 64'(req_ready_o), 64'h2); step();
        req_v_i = 4'b0100; #1; chk("ar_g2", 64'(req_ready_o), 64'h4); step();
        chk("ar_fence_pre", 64'(fence_o), 64'h9);

        // asynchronous reset mid-cycle
        req_v_i = 4'b1111;
        #2;
        reset_i = 1'b1;
        #1;
        chk("ar_fence", 64'(fence_o), 64'hF);
        chk("ar_gb_v", 64'(gb_v_o), 64'h0);
        chk("ar_ready", 64'(req_ready_o), 64'h0);
        step();
        reset_i = 1'b0;
        #1;
        chk("ar_first_grant", 64'(req_ready_o), 64'h1);
        step();

        // stall: requester 1 waits on channel ready
        gb_ready_i = 1'b0;
        req_v_i    = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("st_gb_v", 64'(gb_v_o), 64'h1);
            chk("st_ready", 64'(req_ready_o), 64'h0);
            step();
        end
        gb_ready_i = 1'b1;
        #1; chk("st_grant", 64'(req_ready_o), 64'h2); step();
        req_v_i = 4'b1011;
        #1; chk("st_next", 64'(req_ready_o), 64'h8); step();

        // drain heads 0, 1, 3
        req_v_i = '0;
        gb_v_i  = 1'b1;
        resp_yumi_i = 4'b0001; #1; chk("sd_resp0", 64'(resp_v_o), 64'h1); step();
        resp_yumi_i = 4'b0010; #1; chk("sd_resp1", 64'(resp_v_o), 64'h2); step();
        resp_yumi_i = 4'b1000; #1; chk("sd_resp3", 64'(resp_v_o), 64'h8); step();
        gb_v_i      = 1'b0;
        resp_yumi_i = '0;
        chk("sd_fence", 64'(fence_o), 64'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/bsg_global_buffer_rw_arbiter.md
Name: bsg_global_buffer_rw_arbiter

Overview:
- Shares one global-buffer read/write channel (one rw_* lane of the buffer) among num_req_p independent requesters.
- Performs round-robin arbitration, credit-limits outstanding requests to max_outstanding_p, and routes in-order responses back to the originating requester through an ID tracking FIFO.
- Provides a per-requester fence (no outstanding requests), so each client can order its own writes before dependent reads.

Parameters:
- num_req_p, 4, number of requesters sharing the channel (>=2)
- rw_addr_width_p, 16, request address width
- data_width_p, 32, data width
- max_outstanding_p, 4, maximum in-flight requests on the channel (>=1); depth of the ID FIFO

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-high
- req_addr_i  in  num_req_p x rw_addr_width_p  per-requester address
- req_data_i  in  num_req_p x data_width_p  per-requester write data
- req_w_i  in  num_req_p  1 = write, 0 = read
- req_v_i  in  num_req_p  request valid
- req_ready_o  out  num_req_p  request accepted (at most one bit set)
- resp_data_o  out  num_req_p x data_width_p  response data (broadcast copy of gb_data_i)
- resp_v_o  out  num_req_p  response valid, one-hot
- resp_yumi_i  in  num_req_p  response consumed
- fence_o  out  num_req_p  requester has zero outstanding requests
- gb_addr_o  out  rw_addr_width_p  channel address
- gb_data_o  out  data_width_p  channel write data
- gb_w_o  out  1  channel write enable
- gb_v_o  out  1  channel request valid
- gb_ready_i  in  1  channel ready
- gb_data_i  in  data_width_p  channel response data
- gb_v_i  in  1  channel response valid
- gb_yumi_o  out  1  channel response consumed

Behaviour:
- Reset (async, active-high):
  - RR pointer = 0; ID FIFO empty; total count = 0; all per-requester counts = 0.
  - Outputs during and after reset: fence_o = all 1s; gb_v_o = 0; req_ready_o = 0; resp_v_o = 0; gb_yumi_o = 0.
- Credit: credit_ok = (total_count < max_outstanding_p).
  - total_count is registered and has width clog2(max_outstanding_p + 1).
  - A pop in the same cycle does not free a credit; there is no bypass.
- Arbitration:
  - Grantee g is the first requester with req_v_i set, searching from the RR pointer upward with wrap-around.
  - gb_v_o = |req_v_i & credit_ok & ~reset_i. gb_v_o must not depend on gb_ready_i.
  - gb_addr_o, gb_data_o and gb_w_o are muxed from g.
  - req_ready_o[g] = gb_v_o & gb_ready_i. All other req_ready_o bits are 0.
- Accept (gb_v_o & gb_ready_i):
  - RR pointer <= (g + 1) mod num_req_p.
  - Push g into the ID FIFO; total_count++ and count[g]++.
  - With no accept, the RR pointer holds and an unaccepted requester keeps priority.
- Responses:
  - Every request, read or write, returns exactly one response, in issue order. Write-response data is don't-care.
  - h = ID FIFO head.
  - resp_v_o[h] = gb_v_i & (total_count != 0). All other resp_v_o bits are 0.
  - gb_yumi_o = resp_v_o[h] & resp_yumi_i[h].
  - On gb_yumi_o: pop the FIFO; total_count-- and count[h]--.
  - Latency: combinational pass-through, zero added cycles in either direction.
- Simultaneous push and pop:
  - total_count is unchanged.
  - If g == h, count[g] is unchanged; otherwise count[g]++ and count[h]--.
  - Push and pop at a full FIFO cannot occur, because credit_ok is 0 when full.
- Wrap-around: FIFO read and write pointers wrap modulo max_outstanding_p. Full/empty is decided by total_count, not by pointer comparison.
- Fence: fence_o[i] = (count[i] == 0). It is registered-derived and glitch-free.
- Protocol errors (simulation assertions):
  - gb_v_i while total_count == 0: gb_yumi_o stays 0.
  - resp_yumi_i[i] asserted without resp_v_o[i].
  - Per-requester count overflow.
- Reset mid-operation: all tracking state is discarded. The channel owner is responsible for flushing the buffer; late responses trigger the assertion above.

Decomposition:
- Shared package, bsg_global_buffer_pkg:
  - Request struct macro (addr, data, w).
  - The requester-ID width constant, clog2(num_req_p).
  - The outstanding-count width constant, clog2(max_outstanding_p + 1).
- Sub-module bsg_global_buffer_id_fifo:
  - Circular buffer of requester IDs, max_outstanding_p x clog2(num_req_p).
  - Interface: push/pop/head/count.
  - Async reset.
- Arbitration and per-requester counters stay in the top module.

Test Plan:
- Round-robin fairness: reset, then req_v_i = 4'b1111, gb_ready_i = 1, responses held off. Grants go to 0, 1, 2, 3. The 5th cycle has gb_v_o = 0 (credit exhausted at 4). fence_o = 4'b0000.
- In-order response routing: issue requester 2 read, requester 0 write, requester 2 read. Return gb_v_i with data A, B, C and resp_yumi_i all 1s. Expect resp_v_o = 0100 (A), then 0001 (B), then 0100 (C). fence_o[2] rises only after C.
- Backpressure: resp_yumi_i[h] = 0 for 3 cycles with gb_v_i = 1. gb_yumi_o stays 0, count is unchanged, and resp_data_o holds A.
- Simultaneous push/pop at count = 3 (max = 4): count stays 3. Next cycle credit_ok = 1 and the ID FIFO wraps correctly across 6 further transactions.
- Async reset while 3 requests are outstanding: outputs reset immediately without a clock edge (fence_o = 1111, gb_v_o = 0). After release, the first grant goes to requester 0.
- Stall: gb_ready_i = 0 with req_v_i = 0010. gb_v_o = 1, req_ready_o = 0, and the RR pointer is unchanged. After gb_ready_i = 1, the grant goes to 1 and the next grant search starts at 2.
